circle_point_gen: RTL and testbench

Midpoint-circle point generator that sits directly upstream of the pixel plotting coprocessor. It accepts one circle command with a centre and a radius, walks the first octant with the integer midpoint algorithm, and issues one plot request per octant point. Each request carries x, y, cx and cy packed in the plotter's A/B operand format; the plotter mirrors each point into eight pixels. It replaces the software loop on the Nios side.

---
 rtl/circle_pkg.sv | 24 ++
 rtl/circle_step.sv | 35 +++
 rtl/circle_point_gen.sv | 123 ++++++++++++
 tb/tb_circle_point_gen.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/circle_pkg.sv
// Shared types, constants and operand packing for the midpoint circle generator.
package circle_pkg;

  localparam int unsigned COORD_W = 10;

  typedef enum logic [1:0] {
    StIdle,
    StEmit,
    StFinish
  } circle_state_e;

  // Packs one octant point into the plotter's {A, B} operand pair.
  function automatic logic [63:0] pack_point(input logic [COORD_W-1:0] x,
                                             input logic [COORD_W-1:0] y,
                                             input logic [COORD_W-1:0] cx,
                                             input logic [COORD_W-1:0] cy);
    logic [31:0] a;
    logic [31:0] b;
    a = {cx[1:0], cy, x, y};
    b = {24'b0, cx[COORD_W-1:2]};
    return {a, b};
  endfunction

endpackage

// File: rtl/circle_step.sv
// One combinational midpoint-circle step: (x, y, d) -> (x', y', d', last).
module circle_step #(
  parameter int unsigned R_W = 10
) (
  input  logic [R_W-1:0]        x,
  input  logic [R_W-1:0]        y,
  input  logic signed [R_W+2:0] d,
  output logic [R_W-1:0]        x_nxt,
  output logic [R_W-1:0]        y_nxt,
  output logic signed [R_W+2:0] d_nxt,
  output logic                  last
);

  localparam logic signed [R_W+2:0] One = 1;

  // Wide signed copies so x-1 below zero (r=0) and y+1 past R_W bits compare correctly.
  logic signed [R_W+2:0] xw;
  logic signed [R_W+2:0] yw;

  // Next point and decision variable.
  always_comb begin
    yw = $signed({3'b000, y}) + One;
    if (d < 0) begin
      xw    = $signed({3'b000, x});
      d_nxt = d + (yw <<< 1) + One;
    end else begin
      xw    = $signed({3'b000, x}) - One;
      d_nxt = d + ((yw - xw) <<< 1) + One;
    end
    x_nxt = xw[R_W-1:0];
    y_nxt = yw[R_W-1:0];
    last  = (xw < yw);
  end

endmodule

// File: rtl/circle_point_gen.sv
// Midpoint circle generator: walks the first octant and issues one plot request per point.
module circle_point_gen
  import circle_pkg::*;
#(
  parameter int unsigned R_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_cx,
  input  logic [COORD_W-1:0] cmd_cy,
  input  logic [R_W-1:0]     cmd_r,
  output logic               plot_start,
  output logic [31:0]        plot_A,
  output logic [31:0]        plot_B,
  input  logic               plot_done,
  output logic               busy,
  output logic               circle_done,
  output logic [9:0]         point_count
);

  localparam logic signed [R_W+2:0] One = 1;

  circle_state_e state_q, state_d;

  logic [R_W-1:0]        x_q, y_q;
  logic signed [R_W+2:0] d_q;
  logic [COORD_W-1:0]    cx_q, cy_q;
  logic [31:0]           plot_a_q, plot_b_q;
  logic [9:0]            count_q;

  logic [R_W-1:0]        x_nxt, y_nxt;
  logic signed [R_W+2:0] d_nxt;
  logic                  last;

  circle_step #(
    .R_W (R_W)
  ) u_step (
    .x     (x_q),
    .y     (y_q),
    .d     (d_q),
    .x_nxt (x_nxt),
    .y_nxt (y_nxt),
    .d_nxt (d_nxt),
    .last  (last)
  );

  logic accept_cmd;
  logic accept_pt;
  assign accept_cmd = (state_q == StIdle) && cmd_valid;
  assign accept_pt  = (state_q == StEmit) && plot_done;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (cmd_valid) state_d = StEmit;
      StEmit:   if (plot_done && last) state_d = StFinish;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Decoded status outputs.
  always_comb begin
    cmd_ready   = 1'b0;
    plot_start  = 1'b0;
    busy        = 1'b0;
    circle_done = 1'b0;
    unique case (state_q)
      StIdle:   cmd_ready = 1'b1;
      StEmit:   begin plot_start = 1'b1; busy = 1'b1; end
      StFinish: begin circle_done = 1'b1; busy = 1'b1; end
      default:  cmd_ready = 1'b0;
    endcase
  end

  // Datapath: latch command, advance the walk and register the packed operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q      <= '0;
      y_q      <= '0;
      d_q      <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      plot_a_q <= '0;
      plot_b_q <= '0;
      count_q  <= '0;
    end else if (accept_cmd) begin
      x_q                  <= cmd_r;
      y_q                  <= '0;
      d_q                  <= One - $signed({3'b000, cmd_r});
      cx_q                 <= cmd_cx;
      cy_q                 <= cmd_cy;
      count_q              <= '0;
      {plot_a_q, plot_b_q} <= pack_point(COORD_W'(cmd_r), '0, cmd_cx, cmd_cy);
    end else if (accept_pt) begin
      x_q     <= x_nxt;
      y_q     <= y_nxt;
      d_q     <= d_nxt;
      count_q <= count_q + 10'd1;
      // Keep the last issued point on the bus once the octant is finished.
      if (!last) begin
        {plot_a_q, plot_b_q} <= pack_point(COORD_W'(x_nxt), COORD_W'(y_nxt), cx_q, cy_q);
      end
    end
  end

  assign plot_A      = plot_a_q;
  assign plot_B      = plot_b_q;
  assign point_count = count_q;

endmodule

// File: tb/tb_circle_point_gen.sv
// Scoreboard bench for circle_point_gen.
module tb_circle_point_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_cx, cmd_cy, cmd_r;
  logic        plot_start;
  logic [31:0] plot_A, plot_B;
  logic        plot_done;
  logic        busy;
  logic        circle_done;
  logic [9:0]  point_count;

  circle_point_gen #(
    .R_W (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_cx      (cmd_cx),
    .cmd_cy      (cmd_cy),
    .cmd_r       (cmd_r),
    .plot_start  (plot_start),
    .plot_A      (plot_A),
    .plot_B      (plot_B),
    .plot_done   (plot_done),
    .busy        (busy),
    .circle_done (circle_done),
    .point_count (point_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] exp_q[$];
  int          acc_cnt, done_cnt, start_cnt, cyc;
  int          first_acc_cyc, last_acc_cyc, done_cyc;
  logic [31:0] first_a, first_b;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [63:0] model_pack(input int x, input int y, input int cx, input int cy);
    logic [31:0] a, b;
    a = 32'(((cx & 3) << 30) | ((cy & 1023) << 20) | ((x & 1023) << 10) | (y & 1023));
    b = 32'((cx >> 2) & 255);
    return {a, b};
  endfunction

  // Reference midpoint walk; pushes every expected request.
  task automatic push_circle(input int cx, input int cy, input int r);
    int x, y, d;
    x = r; y = 0; d = 1 - r;
    do begin
      exp_q.push_back(model_pack(x, y, cx, cy));
      y++;
      if (d < 0) d = d + 2 * y + 1;
      else begin
        x--;
        d = d + 2 * (y - x) + 1;
      end
    end while (x >= y);
  endtask

  task automatic clear_stats();
    acc_cnt = 0; done_cnt = 0; start_cnt = 0;
    first_acc_cyc = -1; last_acc_cyc = -1; done_cyc = -1;
    first_a = '0; first_b = '0;
  endtask

  task automatic send_cmd(input int cx, input int cy, input int r);
    push_circle(cx, cy, r);
    @(posedge clk); #1;
    cmd_cx = 10'(cx); cmd_cy = 10'(cy); cmd_r = 10'(r);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      if (circle_done) break;
      n++;
    end
    check_eq("circle_done_seen", 64'(circle_done), 1);
    @(negedge clk);
    check_eq("ready_after_done", 64'(cmd_ready), 1);
    check_eq("done_one_cycle", 64'(circle_done), 0);
  endtask

  // Output monitor: pops the scoreboard on every accepted request.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (plot_start) start_cnt++;
      if (plot_start && plot_done) begin
        check_eq("request_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check_eq("point", {plot_A, plot_B}, exp_q.pop_front());
        if (acc_cnt == 0) begin
          first_acc_cyc = cyc;
          first_a = plot_A;
          first_b = plot_B;
        end
        last_acc_cyc = cyc;
        acc_cnt++;
      end
      if (circle_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    cyc = 0;
    clear_stats();
    reset = 1'b1; cmd_valid = 1'b0; plot_done = 1'b0;
    cmd_cx = '0; cmd_cy = '0; cmd_r = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_cmd_ready", 64'(cmd_ready), 1);
    check_eq("rst_plot_start", 64'(plot_start), 0);
    check_eq("rst_plot_A", 64'(plot_A), 0);
    check_eq("rst_plot_B", 64'(plot_B), 0);
    check_eq("rst_busy", 64'(busy), 0);
    check_eq("rst_circle_done", 64'(circle_done), 0);
    check_eq("rst_point_count", 64'(point_count), 0);

    // r=5, plot_done tied high.
    clear_stats();
    plot_done = 1'b1;
    send_cmd(100, 200, 5);
    @(negedge clk);
    check_eq("first_req_latency", 64'(plot_start), 1);
    check_eq("busy_emit", 64'(busy), 1);
    wait_done();
    check_eq("r5_accepted", 64'(acc_cnt), 4);
    check_eq("r5_consecutive", 64'(last_acc_cyc - first_acc_cyc), 3);
    check_eq("r5_first_A", 64'(first_a), 64'h0C80_1400);
    check_eq("r5_first_B", 64'(first_b), 64'h19);
    check_eq("r5_point_count", 64'(point_count), 4);
    check_eq("r5_done_pulses", 64'(done_cnt), 1);
    check_eq("r5_done_timing", 64'(done_cyc - last_acc_cyc), 1);
    check_eq("r5_queue_empty", 64'(exp_q.size()), 0);

    // r=0 at (10,10): one point.
    clear_stats();
    send_cmd(10, 10, 0);
    wait_done();
    check_eq("r0_accepted", 64'(acc_cnt), 1);
    check_eq("r0_A", 64'(first_a), 64'h80A0_0000);
    check_eq("r0_B", 64'(first_b), 64'h2);
    check_eq("r0_point_count", 64'(point_count), 1);

    // r=5 with a 3-cycle stall on the second point.
    clear_stats();
    send_cmd(100, 200, 5);
    @(posedge clk); #1;
    plot_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_A", 64'(plot_A), 64'h0C80_1401);
      check_eq("stall_start", 64'(plot_start), 1);
      @(posedge clk); #1;
    end
    plot_done = 1'b1;
    @(negedge clk);
    check_eq("stall_A_last", 64'(plot_A), 64'h0C80_1401);
    wait_done();
    check_eq("stall_accepted", 64'(acc_cnt), 4);
    check_eq("stall_point_count", 64'(point_count), 4);

    // cmd_valid pulsed mid-circle must be ignored.
    clear_stats();
    send_cmd(100, 200, 5);
    @(posedge clk); #1;
    cmd_r = 10'd9; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_done();
    repeat (6) @(negedge clk);
    check_eq("ignore_accepted", 64'(acc_cnt), 4);
    check_eq("ignore_starts", 64'(start_cnt), 4);
    check_eq("ignore_point_count", 64'(point_count), 4);

    // Reset after the second accepted point.
    clear_stats();
    send_cmd(100, 200, 5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; plot_done = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_mid_start", 64'(plot_start), 0);
    check_eq("rst_mid_ready", 64'(cmd_ready), 1);
    check_eq("rst_mid_count", 64'(point_count), 0);
    reset = 1'b0; plot_done = 1'b1;
    exp_q.delete();
    repeat (4) @(negedge clk);
    check_eq("rst_mid_accepted", 64'(acc_cnt), 2);
    check_eq("rst_mid_no_done", 64'(done_cnt), 0);
    clear_stats();
    send_cmd(100, 200, 3);
    wait_done();
    check_eq("r3_accepted", 64'(acc_cnt), 3);

    // Wrap-around centre: cx=511.
    clear_stats();
    send_cmd(511, 0, 3);
    wait_done();
    check_eq("wrap_accepted", 64'(acc_cnt), 3);
    check_eq("wrap_A_hi", 64'(first_a[31:30]), 3);
    check_eq("wrap_B", 64'(first_b), 64'h7F);
    check_eq("final_queue_empty", 64'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
